match_sequencer: RTL

Match-level controller for the ping-pong game box: sits between the two key_filter outputs and gameCtrl. It decides whose serve it is and forwards only legal key pulses to gameCtrl. It watches gameCtrl's scores to detect points and game end, clears gameCtrl between games, and keeps a per-player games-won tally for display.

---
 rtl/match_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/match_sequencer.sv
// match_sequencer: match-level controller between the key filters and gameCtrl.
// Decides whose serve it is, forwards only legal key pulses, detects points
// and game end from gameCtrl's scores, and keeps per-player games-won tallies.
module match_sequencer #(
  parameter logic [2:0] WIN_SCORE  = 3'd7,
  parameter int         SERVE_SWAP = 2,
  parameter int         OVER_HOLD  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key1_eff,
  input  logic       key2_eff,
  input  logic [2:0] score_p1,
  input  logic [2:0] score_p2,
  output logic       key1_fwd,
  output logic       key2_fwd,
  output logic       game_clr,
  output logic       server,
  output logic [1:0] state,
  output logic [1:0] winner,
  output logic [3:0] games_p1,
  output logic [3:0] games_p2
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_RALLY = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Hold counter is wide enough to hold OVER_HOLD itself (it saturates there).
  localparam int                HOLD_W   = $clog2(OVER_HOLD + 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD);
  localparam logic [2:0]        SWAP_MAX = 3'(SERVE_SWAP);

  state_t            state_reg, state_next;
  logic              server_reg, server_next;
  logic [1:0]        winner_reg, winner_next;
  logic [2:0]        serve_cnt_reg, serve_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [HOLD_W-1:0] hold_eff;
  logic [2:0]        shadow_p1_reg, shadow_p1_next;
  logic [2:0]        shadow_p2_reg, shadow_p2_next;
  logic              key1_fwd_reg, key1_fwd_next;
  logic              key2_fwd_reg, key2_fwd_next;
  logic              game_clr_reg, game_clr_next;
  logic [1:0]        win_inc;
  logic              point_evt;
  logic              any_key;
  logic [3:0]        games_cnt [2];

  // A point is any change of either score against the last registered copy.
  assign point_evt = (score_p1 != shadow_p1_reg) || (score_p2 != shadow_p2_reg);
  assign any_key   = key1_eff || key2_eff;

  // Register all control state and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      server_reg    <= 1'b0;
      winner_reg    <= 2'b00;
      serve_cnt_reg <= '0;
      hold_cnt_reg  <= '0;
      shadow_p1_reg <= '0;
      shadow_p2_reg <= '0;
      key1_fwd_reg  <= 1'b0;
      key2_fwd_reg  <= 1'b0;
      game_clr_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      server_reg    <= server_next;
      winner_reg    <= winner_next;
      serve_cnt_reg <= serve_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      shadow_p1_reg <= shadow_p1_next;
      shadow_p2_reg <= shadow_p2_next;
      key1_fwd_reg  <= key1_fwd_next;
      key2_fwd_reg  <= key2_fwd_next;
      game_clr_reg  <= game_clr_next;
    end
  end

  // Next-state, key gating, point handling and hold timing for the match FSM.
  always_comb begin
    state_next     = state_reg;
    server_next    = server_reg;
    winner_next    = winner_reg;
    serve_cnt_next = serve_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;
    shadow_p1_next = score_p1;
    shadow_p2_next = score_p2;
    key1_fwd_next  = 1'b0;
    key2_fwd_next  = 1'b0;
    game_clr_next  = 1'b0;
    win_inc        = 2'b00;

    // A tick in the same cycle as a key counts first.
    hold_eff = hold_cnt_reg;
    if (tick && (hold_cnt_reg != HOLD_MAX)) begin
      hold_eff = hold_cnt_reg + HOLD_W'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (any_key) begin
          game_clr_next  = 1'b1;
          server_next    = 1'b0;
          serve_cnt_next = '0;
          state_next     = ST_SERVE;
        end
      end

      ST_SERVE: begin
        // Keys pressed while gameCtrl is still clearing are lost.
        if (!game_clr_reg) begin
          if (!server_reg && key1_eff) begin
            key1_fwd_next = 1'b1;
            state_next    = ST_RALLY;
          end else if (server_reg && key2_eff) begin
            key2_fwd_next = 1'b1;
            state_next    = ST_RALLY;
          end
        end
      end

      ST_RALLY: begin
        if (point_evt) begin
          if (serve_cnt_reg + 3'd1 == SWAP_MAX) begin
            server_next    = ~server_reg;
            serve_cnt_next = '0;
          end else begin
            serve_cnt_next = serve_cnt_reg + 3'd1;
          end
          // Player 1 takes precedence when both reach the winning score.
          if (score_p1 == WIN_SCORE) begin
            winner_next   = 2'b01;
            win_inc       = 2'b01;
            hold_cnt_next = '0;
            state_next    = ST_OVER;
          end else if (score_p2 == WIN_SCORE) begin
            winner_next   = 2'b10;
            win_inc       = 2'b10;
            hold_cnt_next = '0;
            state_next    = ST_OVER;
          end else begin
            state_next = ST_SERVE;
          end
        end else begin
          key1_fwd_next = key1_eff;
          key2_fwd_next = key2_eff;
        end
      end

      ST_OVER: begin
        hold_cnt_next = hold_eff;
        if (any_key && (hold_eff == HOLD_MAX)) begin
          game_clr_next  = 1'b1;
          server_next    = (winner_reg == 2'b01);
          winner_next    = 2'b00;
          serve_cnt_next = '0;
          shadow_p1_next = '0;
          shadow_p2_next = '0;
          state_next     = ST_SERVE;
        end
      end
    endcase
  end

  // One saturating games-won tally per player; bit gi of win_inc selects it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tally
      logic [3:0] tally_reg;

      // Count a won game, holding at 15.
      always_ff @(posedge clk) begin
        if (rst) begin
          tally_reg <= '0;
        end else if (win_inc[gi] && (tally_reg != 4'd15)) begin
          tally_reg <= tally_reg + 4'd1;
        end
      end

      assign games_cnt[gi] = tally_reg;
    end
  endgenerate

  assign state    = state_reg;
  assign server   = server_reg;
  assign winner   = winner_reg;
  assign key1_fwd = key1_fwd_reg;
  assign key2_fwd = key2_fwd_reg;
  assign game_clr = game_clr_reg;
  assign games_p1 = games_cnt[0];
  assign games_p2 = games_cnt[1];

endmodule
